// File: rtl/wb_data_sram.sv
// wb_data_sram: Wishbone B3 classic data SRAM slave, optional wait states via WB_SRAM_WAIT_EN
module wb_data_sram #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h00000400,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(DEPTH);
`ifdef WB_SRAM_WAIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, ACK} state_t;
`endif
  state_t state_q, state_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx_q, idx_d, idx_in;
  logic [31:0] wdat_q, wdat_d, dat_q, dat_d;
  logic [3:0] sel_q, sel_d;
  logic we_q, we_d, ack_q, ack_d;
  logic hit;
  assign idx_in = AW'(wbs_adr_i - BASE_ADDR);
  // ack_q blocks re-sampling the request that is being acknowledged this cycle
  assign hit = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i >= BASE_ADDR) & (wbs_adr_i < END_ADDR);
  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  // next-state, request latching and read/ack generation
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wdat_d = wdat_q;
    sel_d = sel_q;
    we_d = we_q;
    dat_d = dat_q;
    ack_d = 1'b0;
`ifdef WB_SRAM_WAIT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (hit) begin
        idx_d = idx_in;
        wdat_d = wbs_dat_i;
        sel_d = wbs_sel_i;
        we_d = wbs_we_i;
`ifdef WB_SRAM_WAIT_EN
        cnt_d = 4'(WAIT_STATES);
        state_d = (cnt_d != 4'd0) ? WAIT : ACK;
`else
        state_d = ACK;
`endif
      end
`ifdef WB_SRAM_WAIT_EN
      WAIT: begin
        cnt_d = wbs_cyc_i ? cnt_q - 4'd1 : 4'd0;
        state_d = !wbs_cyc_i ? IDLE : (cnt_q == 4'd1) ? ACK : WAIT;
      end
`endif
      ACK: begin
        ack_d = 1'b1;
        dat_d = we_q ? dat_q : mem[idx_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      wdat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      dat_q <= '0;
      ack_q <= 1'b0;
`ifdef WB_SRAM_WAIT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wdat_q <= wdat_d;
      sel_q <= sel_d;
      we_q <= we_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
`ifdef WB_SRAM_WAIT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  // byte-lane write commit when the write is acknowledged; storage is never reset
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACK && we_q)
      for (int b = 0; b < 4; b++)
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
  end
endmodule

// File: tb/tb_wb_data_sram.sv
// tb_wb_data_sram: directed self-checking bench for wb_data_sram
module tb_wb_data_sram;
`ifdef WB_SRAM_WAIT_EN
  localparam int WS = 3;
  localparam int LAT = 4;
`else
  localparam int WS = 0;
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, wdat = '0, rdat;
  logic [3:0] sel = '0;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0, ack;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        ack;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[12];

  wb_data_sram #(.DEPTH(1024), .BASE_ADDR(32'h400), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_dat_o(rdat), .wbs_ack_o(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic got, output int lat);
    repeat (2) @(negedge clk);
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        lat = k - 1;
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    logic got;
    int lat, n;
    logic prev;
    logic [31:0] bexp[4];
    tv[0]  = '{32'h410, 32'h11223344, 4'hF, 1'b1, 1'b1, 32'hDEADBEEF};
    tv[1]  = '{32'h410, 32'hAABBCCDD, 4'h5, 1'b1, 1'b1, 32'hDEADBEEF};
    tv[2]  = '{32'h410, 32'h0,        4'hF, 1'b0, 1'b1, 32'h11BB33DD};
    tv[3]  = '{32'h410, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 32'h11BB33DD};
    tv[4]  = '{32'h410, 32'h0,        4'hF, 1'b0, 1'b1, 32'h11BB33DD};
    tv[5]  = '{32'h7FF, 32'h0BADCAFE, 4'hF, 1'b1, 1'b1, 32'h11BB33DD};
    tv[6]  = '{32'h7FF, 32'h12000000, 4'h8, 1'b1, 1'b1, 32'h11BB33DD};
    tv[7]  = '{32'h7FF, 32'h0,        4'hF, 1'b0, 1'b1, 32'h12ADCAFE};
    tv[8]  = '{32'h3FF, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h12ADCAFE};
    tv[9]  = '{32'h800, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h12ADCAFE};
    tv[10] = '{32'h400, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[11] = '{32'h7FF, 32'h0,        4'hF, 1'b0, 1'b1, 32'h12ADCAFE};
    bexp[0] = 32'hDEADBEEF; bexp[1] = 32'h01010101; bexp[2] = 32'h02020202; bexp[3] = 32'h03030303;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_dat", rdat, 32'h0);
    @(negedge clk) rst = 1'b0;

    xfer(32'h400, 32'h12345678, 4'hF, 1'b1, got, lat);
    chk("w0_ack", 32'(got), 32'd1);
    xfer(32'h400, 32'h0, 4'hF, 1'b0, got, lat);
    chk("r0_dat", rdat, 32'h12345678);

    // reset while a write is pending: it must not commit
    repeat (2) @(negedge clk);
    adr = 32'h400; wdat = 32'h0BAD0BAD; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    xfer(32'h400, 32'h0, 4'hF, 1'b0, got, lat);
    chk("drop_ack", 32'(got), 32'd1);
    chk("drop_dat", rdat, 32'h12345678);
    // async reset in the middle of an ack cycle
    #2 rst = 1'b1;
    #1;
    chk("async_ack", 32'(ack), 32'd0);
    chk("async_dat", rdat, 32'h0);
    @(negedge clk) rst = 1'b0;
    xfer(32'h400, 32'hDEADBEEF, 4'hF, 1'b1, got, lat);
    xfer(32'h400, 32'h0, 4'hF, 1'b0, got, lat);
    chk("post_rst_ack", 32'(got), 32'd1);
    chk("post_rst_dat", rdat, 32'hDEADBEEF);

    for (int i = 0; i < 12; i++) begin
      xfer(tv[i].adr, tv[i].dat, tv[i].sel, tv[i].we, got, lat);
      chk($sformatf("v%0d_ack", i), 32'(got), 32'(tv[i].ack));
      if (tv[i].ack) chk($sformatf("v%0d_lat", i), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_dat", i), rdat, tv[i].exp);
    end

    for (int i = 1; i < 4; i++) xfer(32'h400 + 32'(i), bexp[i], 4'hF, 1'b1, got, lat);
    repeat (2) @(negedge clk);
    adr = 32'h400; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    n = 0;
    prev = 1'b0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(posedge clk); #1;
      if (ack) begin
        chk($sformatf("b2b%0d_gap", n), 32'(prev), 32'd0);
        chk($sformatf("b2b%0d_dat", n), rdat, bexp[n]);
        n++;
        adr = 32'h400 + 32'(n);
      end
      prev = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_count", 32'(n), 32'd4);
    @(posedge clk); #1;
    chk("b2b_tail_ack", 32'(ack), 32'd0);

`ifdef WB_SRAM_WAIT_EN
    xfer(32'h420, 32'h77, 4'hF, 1'b1, got, lat);
    repeat (2) @(negedge clk);
    adr = 32'h420; wdat = 32'h55; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    chk("abort_ack", 32'(n), 32'd0);
    xfer(32'h420, 32'h0, 4'hF, 1'b0, got, lat);
    chk("abort_dat", rdat, 32'h77);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
